// File: rtl/qed_instruction_buffer_pkg.sv
// Shared QED front-end definitions: bubble instruction, mode encoding, default FIFO depth.
package qed_instruction_buffer_pkg;

  localparam int          QED_DEPTH = 8;
  localparam logic [31:0] QED_NOP   = 32'h0000_0013;

  typedef enum logic {
    QED_ORIG = 1'b0,
    QED_DUP  = 1'b1
  } qed_mode_e;

endpackage

// File: rtl/qed_instruction_buffer_fifo.sv
// In-order capture FIFO for original-mode instructions; occupancy is tracked by a
// dedicated counter so full/empty never depend on pointer arithmetic.
module qed_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_x,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          do_push, do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush & ~push;
  assign rd_data = mem[rd_ptr_reg];

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else if (do_push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
      count_next  = count_reg + CW'(1);
    end else if (do_pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
      count_next  = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

endmodule

// File: rtl/qed_instruction_buffer.sv
// Registers fetched instructions for the QED modifier; captures them in original mode
// and replays them in duplicate mode.
module qed_instruction_buffer
  import qed_instruction_buffer_pkg::*;
#(
  parameter int          DEPTH = QED_DEPTH,
  parameter logic [31:0] NOP   = QED_NOP,
  parameter int          CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_x,
  input  logic          qed_ena,
  input  logic          exec_dup,
  input  logic          stall,
  input  logic          flush,
  input  logic [31:0]   ifu_instruction,
  input  logic          ifu_valid,
  output logic          ifu_ready,
  output logic [31:0]   qic_qimux_instruction,
  output logic          qic_valid,
  output logic [CW-1:0] fifo_count,
  output logic          fifo_full,
  output logic          fifo_empty
);

  qed_mode_e   mode;
  logic        accept;
  logic        push, pop;
  logic [31:0] fifo_rd_data;
  logic [31:0] instr_reg, instr_next;
  logic        valid_reg, valid_next;

  assign mode      = qed_mode_e'(exec_dup);
  assign ifu_ready = ~stall & (~qed_ena | ((mode == QED_ORIG) & ~fifo_full));
  assign accept    = ifu_valid & ifu_ready;
  assign push      = qed_ena & (mode == QED_ORIG) & accept & ~flush;
  assign pop       = qed_ena & (mode == QED_DUP) & ~stall & ~fifo_empty & ~flush;

  qed_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_x (reset_x),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (ifu_instruction),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    instr_next = NOP;
    valid_next = 1'b0;
    if (!qed_ena) begin
      instr_next = ifu_instruction;
      valid_next = ifu_valid;
    end else if (mode == QED_ORIG) begin
      if (accept) begin
        instr_next = ifu_instruction;
        valid_next = 1'b1;
      end
    end else if (!fifo_empty) begin
      instr_next = fifo_rd_data;
      valid_next = 1'b1;
    end
  end

  // Flush overrides stall so a squashed bubble always reaches the modifier.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      instr_reg <= NOP;
      valid_reg <= 1'b0;
    end else if (flush) begin
      instr_reg <= NOP;
      valid_reg <= 1'b0;
    end else if (!stall) begin
      instr_reg <= instr_next;
      valid_reg <= valid_next;
    end
  end

  assign qic_qimux_instruction = instr_reg;
  assign qic_valid             = valid_reg;

endmodule
